ftdi_tx_arbiter: RTL and testbench

Shares the FT245-style FTDI byte interface between two transmit requesters and the receive path in ftdi_ctrl. It selects a requester round-robin and locks the grant for a whole packet. Each accepted byte is presented on d/d_asserted as one WR strobe with a gap cycle after it. The block holds off writes while the FTDI has receive data pending, so ftdi_ctrl can run its read sequence. It sits between the packet sources and ftdi_ctrl; d and d_asserted drive ftdi_ctrl directly.

---
 rtl/ftdi_tx_arbiter.sv | 120 ++++++++++++
 tb/tb_ftdi_tx_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_tx_arbiter.sv
// rtl/ftdi_tx_arbiter.sv - round-robin packet-locked write arbiter for the FTDI byte port
module ftdi_tx_arbiter #(
  parameter int unsigned MAX_BURST = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       txe,
  input  logic       rxf,
  input  logic       rd_active,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] d,
  output logic       d_asserted,
  output logic [1:0] grant,
  output logic       busy
);

  localparam logic [15:0] BURST_LIMIT = 16'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, SEND, GAP, YIELD} state_t;

  state_t      state;
  logic        rr_ptr;     // index of the requester served last
  logic        owner;      // index of the requester holding the packet lock
  logic        last_sent;  // byte just written closed its packet
  logic [15:0] burst;

  logic        pick;
  logic        send_idx;
  logic        send_valid;
  logic        send_last;
  logic [7:0]  send_data;

  // Round-robin pick for a new packet, and the source of the next byte to write.
  always_comb begin
    pick       = rr_ptr ? ~req0_valid : req1_valid;
    send_idx   = (state == IDLE) ? pick : owner;
    send_valid = send_idx ? req1_valid : req0_valid;
    send_data  = send_idx ? req1_data  : req0_data;
    send_last  = send_idx ? req1_last  : req0_last;
  end

  // Arbitration FSM; every output is registered, writes are single-cycle strobes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b1;
      owner      <= 1'b0;
      last_sent  <= 1'b0;
      burst      <= 16'd0;
      d          <= 8'd0;
      d_asserted <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      grant      <= 2'b00;
      busy       <= 1'b0;
    end else begin
      d_asserted <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      case (state)
        IDLE: begin
          // Reads win at packet boundaries.
          if ((req0_valid || req1_valid) && rxf && !rd_active) begin
            owner <= pick;
            grant <= pick ? 2'b10 : 2'b01;
            busy  <= 1'b1;
            if (!txe) begin
              d          <= send_data;
              d_asserted <= 1'b1;
              req0_ready <= ~send_idx;
              req1_ready <= send_idx;
              last_sent  <= send_last;
              if (burst != BURST_LIMIT) burst <= burst + 16'd1;
              state      <= SEND;
            end else begin
              state <= GAP;
            end
          end
        end
        SEND: begin
          state <= GAP;
        end
        GAP: begin
          if (last_sent) begin
            rr_ptr    <= owner;
            grant     <= 2'b00;
            busy      <= 1'b0;
            burst     <= 16'd0;
            last_sent <= 1'b0;
            state     <= rxf ? IDLE : YIELD;
          end else if ((burst == BURST_LIMIT) && !rxf) begin
            // Mid-packet yield: the lock (grant/busy) is kept.
            burst <= 16'd0;
            state <= YIELD;
          end else if (send_valid && !txe && !rd_active) begin
            d          <= send_data;
            d_asserted <= 1'b1;
            req0_ready <= ~send_idx;
            req1_ready <= send_idx;
            last_sent  <= send_last;
            if (burst != BURST_LIMIT) burst <= burst + 16'd1;
            state      <= SEND;
          end
        end
        YIELD: begin
          if (rxf && !rd_active) state <= (grant != 2'b00) ? GAP : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// tb/tb_ftdi_tx_arbiter.sv - self-checking bench for ftdi_tx_arbiter
module tb_ftdi_tx_arbiter;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       txe, rxf, rd_active;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic [7:0] d;
  logic       d_asserted;
  logic [1:0] grant;
  logic       busy;

  always #5 clk = ~clk;

  ftdi_tx_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .n_rst(n_rst), .txe(txe), .rxf(rxf), .rd_active(rd_active),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .d(d), .d_asserted(d_asserted), .grant(grant), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // requester packet queues: {last, data}
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] sent_log[$];
  logic [7:0] exp_log[$];
  logic [1:0] grant_log[$];
  int         pulse_cnt, rdy0_cnt, rdy1_cnt;
  bit         rand_stall;

  // reference model state
  bit         model_rr;
  logic [1:0] prev_grant;
  logic       prev_das;

  // inputs as the DUT saw them at the last rising edge
  logic s_txe, s_rxf, s_rd, s_v0, s_v1;
  always @(posedge clk) begin
    s_txe <= txe;
    s_rxf <= rxf;
    s_rd  <= rd_active;
    s_v0  <= req0_valid;
    s_v1  <= req1_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model checks plus requester behaviour, run once per falling edge.
  task automatic step();
    logic [1:0] exp_g;
    logic [8:0] head;
    if (!n_rst) begin
      model_rr   = 1'b1;
      prev_grant = 2'b00;
      prev_das   = 1'b0;
    end else begin
      check("busy_vs_grant", busy, grant != 2'b00);
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        if (model_rr) exp_g = s_v0 ? 2'b01 : 2'b10;
        else          exp_g = s_v1 ? 2'b10 : 2'b01;
        check("rr_grant", grant, exp_g);
        grant_log.push_back(grant);
      end
      if (grant != 2'b00 && prev_grant != 2'b00) check("grant_lock", grant, prev_grant);
      if (d_asserted) begin
        check("single_pulse", prev_das, 0);
        check("holdoff_txe_rd", {s_txe, s_rd}, 0);
        if (prev_grant == 2'b00) check("idle_rxf", s_rxf, 1);
        check("ready_owner", {req1_ready, req0_ready}, grant);
        if (grant == 2'b01 || grant == 2'b10) begin
          if ((grant[1] ? q1.size() : q0.size()) == 0) begin
            check("byte_avail", 0, 1);
          end else begin
            head = grant[1] ? q1[0] : q0[0];
            check("byte", d, head[7:0]);
            if (head[8]) model_rr = grant[1];
          end
        end else begin
          check("das_with_grant", grant, 2'b01);
        end
        sent_log.push_back(d);
        pulse_cnt++;
      end else begin
        check("ready_idle", {req1_ready, req0_ready}, 0);
      end
      if (req0_ready) rdy0_cnt++;
      if (req1_ready) rdy1_cnt++;
      prev_grant = grant;
      prev_das   = d_asserted;
    end
    if (n_rst && req0_ready && q0.size() > 0) void'(q0.pop_front());
    if (n_rst && req1_ready && q1.size() > 0) void'(q1.pop_front());
    req0_valid = (q0.size() > 0) && !(rand_stall && $urandom_range(0, 3) == 0);
    req1_valid = (q1.size() > 0) && !(rand_stall && $urandom_range(0, 3) == 0);
    req0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    req0_last  = (q0.size() > 0) ? q0[0][8]   : 1'b0;
    req1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    req1_last  = (q1.size() > 0) ? q1[0][8]   : 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    step();
  endtask

  task automatic push_pkt(input int r, input logic [7:0] base, input int len, input bit rnd);
    logic [8:0] v;
    for (int i = 0; i < len; i++) begin
      v = {(i == len - 1), rnd ? 8'($urandom_range(0, 255)) : 8'(base + i)};
      if (r == 0) q0.push_back(v);
      else        q1.push_back(v);
    end
  endtask

  task automatic start_reset();
    n_rst = 1'b0; txe = 1'b0; rxf = 1'b1; rd_active = 1'b0; rand_stall = 1'b0;
    q0.delete(); q1.delete(); sent_log.delete(); grant_log.delete(); exp_log.delete();
    pulse_cnt = 0; rdy0_cnt = 0; rdy1_cnt = 0;
    tick();
  endtask

  task automatic release_reset();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int c = 0;
    while (pulse_cnt < n && c < budget) begin
      tick();
      c++;
    end
    if (pulse_cnt < n) check("timeout_pulses", pulse_cnt, n);
  endtask

  task automatic settle();
    int c = 0;
    tick();
    while (busy && c < 200) begin
      tick();
      c++;
    end
    check("settle_busy", busy, 0);
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_count"}, sent_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < sent_log.size(); i++)
      check(tag, sent_log[i], exp_log[i]);
  endtask

  initial begin
    logic [5:0] pat;
    bit         g_ok;
    int         zero_cnt;
    int         total, c;
    n_rst = 1'b0; txe = 1'b0; rxf = 1'b1; rd_active = 1'b0;
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    rand_stall = 1'b0;

    // T1: reset values, then a 3-byte packet
    start_reset();
    check("rst_d", d, 0);
    check("rst_das", d_asserted, 0);
    check("rst_ready", {req1_ready, req0_ready}, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    push_pkt(0, 8'hA1, 3, 0);
    exp_log = '{8'hA1, 8'hA2, 8'hA3};
    release_reset();
    wait_pulses(1, 50);
    pat = 6'b0; g_ok = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      if (i != 5) tick();
      pat[i] = d_asserted;
      if (grant != 2'b01) g_ok = 1'b0;
    end
    check("t1_das_pattern", pat, 6'b101010);
    check("t1_grant_held", g_ok, 1);
    check("t1_busy_last_gap", busy, 1);
    tick();
    check("t1_busy_end", busy, 0);
    check("t1_grant_end", grant, 0);
    check("t1_ready0_cnt", rdy0_cnt, 3);
    check("t1_ready1_cnt", rdy1_cnt, 0);
    compare_log("t1_bytes");

    // T2: both requesters always valid -> packets alternate
    start_reset();
    for (int p = 0; p < 3; p++) begin
      push_pkt(0, 8'h10, 2, 0);
      push_pkt(1, 8'h20, 2, 0);
      exp_log.push_back(8'h10); exp_log.push_back(8'h11);
      exp_log.push_back(8'h20); exp_log.push_back(8'h21);
    end
    release_reset();
    wait_pulses(12, 400);
    settle();
    compare_log("t2_bytes");
    check("t2_grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check("t2_grant_seq", grant_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);

    // T3: FTDI FIFO full for 5 cycles after the first byte
    start_reset();
    push_pkt(0, 8'h30, 4, 0);
    exp_log = '{8'h30, 8'h31, 8'h32, 8'h33};
    release_reset();
    wait_pulses(1, 50);
    txe = 1'b1;
    zero_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!d_asserted) zero_cnt++;
    end
    txe = 1'b0;
    check("t3_stall_cycles", zero_cnt, 5);
    tick();
    check("t3_resume", d_asserted, 1);
    wait_pulses(4, 50);
    settle();
    compare_log("t3_bytes");

    // T4: burst limit of 4 with a pending read mid-packet
    start_reset();
    push_pkt(0, 8'h40, 10, 0);
    push_pkt(1, 8'h50, 2, 0);
    for (int i = 0; i < 10; i++) exp_log.push_back(8'(8'h40 + i));
    exp_log.push_back(8'h50); exp_log.push_back(8'h51);
    release_reset();
    wait_pulses(2, 50);
    rxf = 1'b0;
    repeat (10) tick();
    check("t4_yield_bytes", pulse_cnt, 4);
    check("t4_yield_grant", grant, 2'b01);
    check("t4_yield_busy", busy, 1);
    rxf = 1'b1; rd_active = 1'b1;
    repeat (3) tick();
    check("t4_rd_block", pulse_cnt, 4);
    rd_active = 1'b0;
    wait_pulses(12, 200);
    settle();
    compare_log("t4_bytes");
    check("t4_grants", grant_log.size(), 2);

    // T5: receive data pending at IDLE, then read in progress
    start_reset();
    rxf = 1'b0;
    push_pkt(0, 8'h60, 2, 0);
    exp_log = '{8'h60, 8'h61};
    release_reset();
    repeat (10) tick();
    check("t5_rxf_block", pulse_cnt, 0);
    check("t5_rxf_grant", grant, 0);
    rxf = 1'b1; rd_active = 1'b1;
    repeat (8) tick();
    check("t5_rd_block", pulse_cnt, 0);
    check("t5_rd_grant", grant, 0);
    rd_active = 1'b0;
    tick();
    check("t5_first_write", d_asserted, 1);
    wait_pulses(2, 50);
    settle();
    compare_log("t5_bytes");

    // T6: reset in the middle of a packet
    start_reset();
    push_pkt(0, 8'h70, 6, 0);
    release_reset();
    wait_pulses(3, 50);
    n_rst = 1'b0;
    #1;
    check("t6_async_outputs", {d, d_asserted, req0_ready, req1_ready, busy}, 0);
    check("t6_async_grant", grant, 0);
    q0.delete(); q1.delete(); sent_log.delete(); grant_log.delete();
    pulse_cnt = 0;
    push_pkt(1, 8'h80, 2, 0);
    push_pkt(0, 8'h90, 2, 0);
    tick();
    release_reset();
    wait_pulses(4, 100);
    settle();
    check("t6_first_grant", grant_log.size() > 0 ? grant_log[0] : 2'b00, 2'b01);
    check("t6_first_byte", sent_log.size() > 0 ? sent_log[0] : 8'h00, 8'h90);

    // T7: random traffic, stalls and FTDI handshakes against the model
    start_reset();
    total = 0;
    for (int p = 0; p < 10; p++) begin
      for (int r = 0; r < 2; r++) begin
        c = $urandom_range(1, 6);
        total += c;
        push_pkt(r, 8'h00, c, 1);
      end
    end
    rand_stall = 1'b1;
    release_reset();
    c = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy) && c < 20000) begin
      txe       = ($urandom_range(0, 9) < 3);
      rxf       = ($urandom_range(0, 9) >= 2);
      rd_active = ($urandom_range(0, 9) < 2);
      tick();
      c++;
    end
    check("t7_finished", c < 20000, 1);
    check("t7_byte_total", pulse_cnt, total);
    check("t7_q0_empty", q0.size(), 0);
    check("t7_q1_empty", q1.size(), 0);
    check("t7_packets", grant_log.size(), 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
